fifo512: RTL and testbench

FIFO512 -- requirements
Module: fifo512

---
 rtl/fifo512.sv | 162 ++++++++++++++++
 tb/tb_fifo512.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo512.sv
// ---------------------------------------------------------------------------
// fifo512 -- 512-entry synchronous FIFO with first-word-fall-through read.
//
// Storage is a single distram512d (synchronous write, combinational read).
// It is addressed by the low 9 bits of two 10-bit wrapping pointers. The
// extra MSB separates "full" from "empty" when the low bits are equal.
//
// Optional feature macro: FIFO512_ERR_FLAGS_EN
//   defined   : overflow/underflow are sticky flags. They are set on a push
//               attempt while full or a pop attempt while empty, and they
//               are cleared by flush or reset.
//   undefined : overflow/underflow are tied to 0 and have no registers.
//
// Parameters:
//   WIDTH        data width in bits (default 32)
//   AFULL_LEVEL  level at which almost_full asserts, 1..512 (default 448)
//
// Ports:
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset (release synchronised outside)
//   flush        synchronous clear of all contents; wins over push/pop
//   wr_data      push data
//   wr_valid     push request
//   wr_ready     FIFO not full
//   rd_data      head-of-FIFO data (valid while rd_valid)
//   rd_valid     FIFO not empty
//   rd_ready     pop request
//   level        entry count 0..512
//   almost_full  level >= AFULL_LEVEL
//   overflow     sticky push-while-full flag (see macro above)
//   underflow    sticky pop-while-empty flag (see macro above)
// ---------------------------------------------------------------------------

// distram512d -- 512-deep distributed RAM: one synchronous write port with
// per-bit write enables and one combinational read port.
module distram512d #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic [8:0]       a_addr,
    input  logic [WIDTH-1:0] a_wrdata,
    input  logic [WIDTH-1:0] a_wren,
    input  logic [8:0]       b_addr,
    output logic [WIDTH-1:0] b_rddata
);

    logic [WIDTH-1:0] mem_r [512];

    // Write port: merge enabled bits of the new word into the stored word.
    always_ff @(posedge clk) begin
        if (|a_wren) begin
            mem_r[a_addr] <= (mem_r[a_addr] & ~a_wren) | (a_wrdata & a_wren);
        end
    end

    assign b_rddata = mem_r[b_addr];

endmodule

module fifo512 #(
    parameter int WIDTH       = 32,
    parameter int AFULL_LEVEL = 448
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [9:0]       level,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [9:0] AFULL_LVL = 10'(AFULL_LEVEL);

    logic [9:0]       wr_ptr_r;
    logic [9:0]       rd_ptr_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] wren_s;

    // Equal low bits mean either empty or full; the MSB tells which lap we are on.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[9] != rd_ptr_r[9]) && (wr_ptr_r[8:0] == rd_ptr_r[8:0]);

    assign wr_ready    = ~full_s;
    assign rd_valid    = ~empty_s;
    assign level       = wr_ptr_r - rd_ptr_r;
    assign almost_full = (level >= AFULL_LVL);

    // A pop in the same cycle does not open a slot for a push while full.
    // Flush suppresses both operations.
    assign push_s = wr_valid & ~full_s & ~flush;
    assign pop_s  = rd_ready & ~empty_s & ~flush;
    assign wren_s = {WIDTH{push_s}};

    distram512d #(
        .WIDTH (WIDTH)
    ) u_ram (
        .clk      (clk),
        .a_addr   (wr_ptr_r[8:0]),
        .a_wrdata (wr_data),
        .a_wren   (wren_s),
        .b_addr   (rd_ptr_r[8:0]),
        .b_rddata (rd_data)
    );

    // Pointer registers: async reset, flush clears, otherwise advance on push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= 10'd0;
            rd_ptr_r <= 10'd0;
        end else if (flush) begin
            wr_ptr_r <= 10'd0;
            rd_ptr_r <= 10'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 10'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 10'd1;
            end
        end
    end

`ifdef FIFO512_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags; only flush or reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_valid && full_s) begin
                overflow_r <= 1'b1;
            end
            if (rd_ready && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo512.sv
// ---------------------------------------------------------------------------
// tb_fifo512 -- scoreboard bench for fifo512.
// The reference model keeps an occupancy count and a queue of expected words.
// The monitor compares every DUT output against the model on each falling
// edge. It also pops the expected-data queue whenever the DUT presents a word
// that is being consumed.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fifo512;

    localparam int WIDTH = 32;
    localparam int AFULL = 448;
    localparam int DEPTH = 512;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [9:0]       level;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [WIDTH-1:0] exp_q[$];
    int               m_level = 0;
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;

    fifo512 #(.WIDTH(WIDTH), .AFULL_LEVEL(AFULL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: applies the FIFO rules at each rising edge (or async reset).
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                exp_q.delete();
                m_level = 0;
                m_ovf   = 1'b0;
                m_unf   = 1'b0;
            end else if (flush) begin
                exp_q.delete();
                m_level = 0;
                m_ovf   = 1'b0;
                m_unf   = 1'b0;
            end else begin
                bit do_push;
                bit do_pop;
                do_push = wr_valid && (m_level < DEPTH);
                do_pop  = rd_ready && (m_level > 0);
`ifdef FIFO512_ERR_FLAGS_EN
                if (wr_valid && m_level == DEPTH) m_ovf = 1'b1;
                if (rd_ready && m_level == 0)     m_unf = 1'b1;
`endif
                if (do_push) exp_q.push_back(wr_data);
                m_level = m_level + int'(do_push) - int'(do_pop);
            end
        end
    end

    // Monitor: compares DUT outputs with the model and retires consumed words.
    initial begin
        forever begin
            @(negedge clk);
            chk("level",       64'(level),       64'(m_level));
            chk("wr_ready",    64'(wr_ready),    64'(m_level != DEPTH));
            chk("rd_valid",    64'(rd_valid),    64'(m_level != 0));
            chk("almost_full", 64'(almost_full), 64'(m_level >= AFULL));
            chk("overflow",    64'(overflow),    64'(m_ovf));
            chk("underflow",   64'(underflow),   64'(m_unf));
            if (reset_n && rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty actual=rd_valid_1 expected=no_data at %0t", $time);
                end else begin
                    chk("rd_data", 64'(rd_data), 64'(exp_q[0]));
                    if (rd_ready && !flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Drive one cycle of inputs, then wait until just after the next rising edge.
    task automatic step(input bit wv, input logic [WIDTH-1:0] wd, input bit rr, input bit fl);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level",    64'(level),    64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        reset_n = 1'b1;

        // basic ordering
        step(1'b1, 32'h1111_1111, 1'b0, 1'b0);
        chk("first_valid", 64'(rd_valid), 64'd1);
        chk("first_data",  64'(rd_data),  64'h1111_1111);
        step(1'b1, 32'h2222_2222, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("second_data", 64'(rd_data), 64'h2222_2222);
        chk("one_level",   64'(level),   64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // fill to full, then one extra push
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(32'hA000_0000 + i), 1'b0, 1'b0);
        chk("full_ready", 64'(wr_ready),    64'd0);
        chk("full_level", 64'(level),       64'd512);
        chk("full_afull", 64'(almost_full), 64'd1);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("extra_level", 64'(level), 64'd512);
`ifdef FIFO512_ERR_FLAGS_EN
        chk("overflow_set", 64'(overflow), 64'd1);
`endif
        // pop while full with a push attempt: push refused
        step(1'b1, 32'hBAD0_0001, 1'b1, 1'b0);
        chk("full_popush_level", 64'(level), 64'd511);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // streaming across pointer wrap
        for (int k = 0; k < 2000; k++) begin
            step(1'b1, WIDTH'(k), 1'b1, 1'b0);
            if (k > 0 && level != 10'd1) chk("stream_level", 64'(level), 64'd1);
        end
        chk("stream_end_level", 64'(level), 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // pop while empty with simultaneous push
        step(1'b1, 32'h5555_5555, 1'b1, 1'b0);
        chk("empty_popush_level", 64'(level), 64'd1);
`ifdef FIFO512_ERR_FLAGS_EN
        chk("underflow_set", 64'(underflow), 64'd1);
`endif

        // flush at level 300 with push and pop active
        for (int i = 0; i < 299; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        chk("pre_flush_level", 64'(level), 64'd300);
        step(1'b1, 32'h7777_7777, 1'b1, 1'b1);
        chk("flush_level", 64'(level),     64'd0);
        chk("flush_valid", 64'(rd_valid),  64'd0);
        chk("flush_unf",   64'(underflow), 64'd0);
        chk("flush_ovf",   64'(overflow),  64'd0);

        // async reset pulse at level 100
        for (int i = 0; i < 100; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        wr_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_level", 64'(level),    64'd0);
        chk("areset_ready", 64'(wr_ready), 64'd1);
        chk("areset_valid", 64'(rd_valid), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
        chk("post_reset_head", 64'(rd_data), 64'hCAFE_0001);
        step(1'b1, 32'hCAFE_0002, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_reset_level", 64'(level), 64'd0);

        // randomized traffic: push-heavy, balanced, pop-heavy phases
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 1200; c++) begin
                bit wv;
                bit rr;
                bit fl;
                wv = ($urandom_range(0, 9) < ((ph == 0) ? 9 : (ph == 1) ? 5 : 2));
                rr = ($urandom_range(0, 9) < ((ph == 0) ? 3 : (ph == 1) ? 5 : 8));
                fl = ($urandom_range(0, 399) == 0);
                step(wv, $urandom, rr, fl);
            end
        end

        step(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
